// File: rtl/cpu_muldiv_ctrl_if.sv
// Handshake/bus bundle between the EX stage and the mul/div sequencer.
interface cpu_muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_req;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    modport master (
        output op_valid, op, a, b, rd_req, flush,
        input  hi, lo, busy, stall
    );

    modport slave (
        input  op_valid, op, a, b, rd_req, flush,
        output hi, lo, busy, stall
    );
endinterface

// File: rtl/cpu_muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, one
// step per cycle, followed by a single sign fix-up/writeback cycle.
module cpu_muldiv_ctrl #(
    parameter int unsigned ITER = 32
) (
    input logic              clk,
    input logic              clr_n,
    cpu_muldiv_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    typedef enum logic [2:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
    } op_t;

    state_t      state;
    state_t      state_nxt;
    op_t         op_dec;

    logic [CW-1:0] cnt;
    logic [31:0]   acc_hi;
    logic [31:0]   acc_lo;
    logic [31:0]   opb;
    logic          is_div;
    logic          neg_q;
    logic          neg_r;
    logic          dz;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;

    logic          start;
    logic          mthi_we;
    logic          mtlo_we;
    logic          fix_we;

    logic          signed_op;
    logic          div_op;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;

    logic [32:0]   mul_sum;
    logic [32:0]   div_shift;
    logic [33:0]   div_diff;

    logic [63:0]   prod;
    logic [63:0]   prod_fix;
    logic [31:0]   quo_fix;
    logic [31:0]   rem_fix;

    assign op_dec    = op_t'(bus.op);
    assign signed_op = (op_dec == OP_MULT) || (op_dec == OP_DIV);
    assign div_op    = (op_dec == OP_DIV) || (op_dec == OP_DIVU);
    assign a_mag     = (signed_op && bus.a[31]) ? -bus.a : bus.a;
    assign b_mag     = (signed_op && bus.b[31]) ? -bus.b : bus.b;

    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign bus.busy  = (state != IDLE);
    assign bus.stall = bus.busy && (bus.op_valid || bus.rd_req);

    // State register.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes; flush overrides accept, MT* and writeback.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        mthi_we   = 1'b0;
        mtlo_we   = 1'b0;
        fix_we    = 1'b0;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        case (op_dec)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                start     = 1'b1;
                                state_nxt = RUN;
                            end
                            OP_MTHI: mthi_we = 1'b1;
                            OP_MTLO: mtlo_we = 1'b1;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state_nxt = FIX;
                    end
                end
                FIX: begin
                    fix_we    = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};
    end

    // Sign fix-up; a zero divisor keeps the all-ones quotient so the
    // remainder path alone restores the original dividend into HI.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = (neg_q && !dz) ? -acc_lo : acc_lo;
        rem_fix  = neg_r ? -acc_hi : acc_hi;
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (start) begin
            cnt    <= CW'(ITER - 1);
            acc_hi <= '0;
            acc_lo <= div_op ? a_mag : b_mag;
            opb    <= div_op ? b_mag : a_mag;
            is_div <= div_op;
            neg_q  <= signed_op && (bus.a[31] ^ bus.b[31]);
            neg_r  <= signed_op && div_op && bus.a[31];
            dz     <= div_op && (bus.b == '0);
        end else if ((state == RUN) && !bus.flush) begin
            cnt <= cnt - 1'b1;
            if (is_div) begin
                if (!div_diff[33]) begin
                    acc_hi <= div_diff[31:0];
                    acc_lo <= {acc_lo[30:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[31:0];
                    acc_lo <= {acc_lo[30:0], 1'b0};
                end
            end else begin
                acc_hi <= mul_sum[32:1];
                acc_lo <= {mul_sum[0], acc_lo[31:1]};
            end
        end
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (mthi_we) begin
            hi_r <= bus.a;
        end else if (mtlo_we) begin
            lo_r <= bus.a;
        end else if (fix_we) begin
            hi_r <= is_div ? rem_fix : prod_fix[63:32];
            lo_r <= is_div ? quo_fix : prod_fix[31:0];
        end
    end

endmodule

// File: tb/tb_cpu_muldiv_ctrl.sv
// Directed self-checking bench for the mul/div sequencer.
module tb_cpu_muldiv_ctrl;

    logic clk;
    logic clr_n;
    int   checks;
    int   failures;

    localparam logic [2:0] C_MULT  = 3'd1;
    localparam logic [2:0] C_MULTU = 3'd2;
    localparam logic [2:0] C_DIV   = 3'd3;
    localparam logic [2:0] C_DIVU  = 3'd4;
    localparam logic [2:0] C_MTHI  = 3'd5;
    localparam logic [2:0] C_MTLO  = 3'd6;

    cpu_muldiv_ctrl_if bus();

    cpu_muldiv_ctrl #(.ITER(32)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.a        = '0;
        bus.b        = '0;
        bus.rd_req   = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.a        = v;
        tick();
        idle_inputs();
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            tick();
        end
        check({tag, "_lat"}, 32'(n), 32'd33);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        tick();
        idle_inputs();
        #1;
        wait_idle(tag);
        check({tag, "_hi"}, bus.hi, eh);
        check({tag, "_lo"}, bus.lo, el);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        clr_n    = 1'b0;
        idle_inputs();
        tick();
        tick();
        clr_n = 1'b1;
        #1;
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // Random activity, then a two-cycle reset.
        mt(C_MTHI, $urandom);
        mt(C_MTLO, $urandom | 32'h1);
        bus.op_valid = 1'b1; bus.op = C_MULT; bus.a = $urandom; bus.b = $urandom;
        tick();
        idle_inputs();
        tick(); tick();
        clr_n = 1'b0;
        bus.rd_req = 1'b1;
        tick(); tick();
        clr_n = 1'b1;
        #1;
        check("rst2_hi", bus.hi, 32'h0);
        check("rst2_lo", bus.lo, 32'h0);
        check("rst2_busy", 32'(bus.busy), 32'd0);
        check("rst2_stall", 32'(bus.stall), 32'd0);
        bus.rd_req = 1'b0;
        tick();

        // Multiply / divide vectors.
        run_op("mult_m2x3",   C_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_m2x3",  C_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA);
        run_op("mult_m1xm1",  C_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'h1);
        run_op("multu_max",   C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7d2",    C_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2",    C_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_7d0",    C_DIVU,  32'd7,        32'd0,        32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_m7d0",    C_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf",     C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000);
        run_op("divu_big",    C_DIVU,  32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF);

        // MTHI in IDLE.
        mt(C_MTHI, 32'hDEAD_BEEF);
        check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi_busy", 32'(bus.busy), 32'd0);

        // Stall while MFLO waits on a MULT.
        bus.op_valid = 1'b1; bus.op = C_MULT; bus.a = 32'd5; bus.b = 32'd6; bus.rd_req = 1'b1;
        tick();
        bus.op_valid = 1'b0; bus.op = 3'd0;
        #1;
        n = 0;
        while (bus.stall && n < 40) begin
            n++;
            tick();
        end
        check("stall_len", 32'(n), 32'd33);
        check("stall_lo", bus.lo, 32'd30);
        check("stall_hi", bus.hi, 32'd0);
        bus.rd_req = 1'b0;
        tick();

        // Back-to-back: DIV held on op_valid behind a MULT.
        bus.op_valid = 1'b1; bus.op = C_MULT; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.op = C_DIV; bus.a = 32'd100; bus.b = 32'd7;
        #1;
        n = 0;
        while (bus.stall && n < 40) begin
            n++;
            tick();
        end
        check("b2b_stall_len", 32'(n), 32'd33);
        check("b2b_mul_lo", bus.lo, 32'd700);
        check("b2b_idle", 32'(bus.busy), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("b2b_accept", 32'(bus.busy), 32'd1);
        wait_idle("b2b_div");
        check("b2b_div_hi", bus.hi, 32'd2);
        check("b2b_div_lo", bus.lo, 32'd14);

        // Flush in RUN leaves HI/LO untouched.
        mt(C_MTHI, 32'h1234);
        mt(C_MTLO, 32'h5678);
        bus.op_valid = 1'b1; bus.op = C_MULT; bus.a = 32'd9; bus.b = 32'd9;
        tick();
        idle_inputs();
        for (int unsigned i = 0; i < 4; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        check("flush_busy", 32'(bus.busy), 32'd0);
        for (int unsigned i = 0; i < 40; i++) tick();
        check("flush_hi", bus.hi, 32'h1234);
        check("flush_lo", bus.lo, 32'h5678);

        // Flush concurrent with MTLO.
        bus.op_valid = 1'b1; bus.op = C_MTLO; bus.a = 32'hAAAA_AAAA; bus.flush = 1'b1;
        tick();
        idle_inputs();
        #1;
        check("flush_mtlo_lo", bus.lo, 32'h5678);
        check("flush_mtlo_busy", 32'(bus.busy), 32'd0);

        // Reset during RUN.
        bus.op_valid = 1'b1; bus.op = C_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        idle_inputs();
        for (int unsigned i = 0; i < 9; i++) tick();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        #1;
        check("rstrun_busy", 32'(bus.busy), 32'd0);
        check("rstrun_hi", bus.hi, 32'h0);
        check("rstrun_lo", bus.lo, 32'h0);
        for (int unsigned i = 0; i < 40; i++) tick();
        check("rstrun_late_lo", bus.lo, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_muldiv_ctrl.md
Name: cpu_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer alongside the EX-stage ALU; owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs multi-cycle ops as a shift-add / restoring-divide FSM.
- Drives a stall request to the pipeline while a result is pending and EX needs the unit or HI/LO.

Parameters:
- ITER, 32, number of iteration cycles per mul/div; equals operand width; only 32 is supported.

Ports:
- clk  in  1  global clock
- clr_n  in  1  synchronous active-low reset
- op_valid  in  1  EX presents a muldiv op this cycle
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- b  in  32  rt operand (divisor / multiplier)
- rd_req  in  1  EX instruction is MFHI/MFLO this cycle
- flush  in  1  abort any in-flight op (exception/redirect)
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  FSM not IDLE
- stall  out  1  pipeline stall request to IF/ID/EX

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-low (clr_n). When clr_n=0 at a posedge: state=IDLE, hi=0, lo=0, busy=0, internal counter/operands=0. Reset mid-operation discards the op.
- stall = busy & (op_valid | rd_req), combinational. Not asserted in IDLE.
- Accept rule: an op is accepted only when state=IDLE, op_valid=1 and flush=0. While busy, op_valid is held by the stalled pipeline and accepted on the first IDLE cycle.
- MTHI/MTLO: single-cycle. hi (or lo) <= a at the accepting edge. The state stays IDLE.
- FSM states: IDLE, RUN, FIX.
- IDLE -> RUN on accepting MULT/MULTU/DIV/DIVU:
  - latch |a| and |b| (signed ops) or raw a and b (unsigned);
  - latch the result sign: a[31]^b[31] for the product/quotient, a[31] for the remainder;
  - cnt <= ITER-1.
- RUN: performs one shift-add (mul) or restoring-subtract (div) step per cycle; cnt decrements. At cnt=0 -> FIX.
- FIX: applies the two's-complement sign fix-up, writes hi/lo at the FIX edge, then -> IDLE.
- Latency: accept at edge N. busy=1 from N+1 through N+33. New hi/lo visible after edge N+33, the same edge busy falls.
- Mul result: {hi,lo} = 64-bit product (signed for MULT, unsigned for MULTU).
- Div result: lo = quotient, hi = remainder; quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU): full latency, no trap; lo=32'hFFFF_FFFF, hi=a as latched at accept.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- flush=1 in any state: next state IDLE, hi/lo unchanged, nothing accepted that cycle. flush takes priority over accept, FIX writeback and MTHI/MTLO.
- hi/lo are registered outputs; MFHI/MFLO read them directly once stall drops.

Test Plan:
- Reset: clr_n=0 for 2 cycles after random ops -> hi=lo=0, busy=stall=0; clr_n=0 during RUN (cycle 10) -> IDLE, hi/lo=0.
- MULT a=0xFFFF_FFFE (-2), b=3 -> after 33 busy cycles hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. MULTU with the same operands -> hi=0x2, lo=0xFFFF_FFFA.
- DIV a=-7 (0xFFFF_FFF9), b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU a=7, b=0 -> lo=0xFFFF_FFFF, hi=7.
- Stall: accept MULT, then hold rd_req=1 -> stall=1 for exactly 33 cycles, then 0 with the new lo visible. A back-to-back DIV held on op_valid is accepted on the first IDLE edge.
- Flush at RUN cycle 5 with prior hi=0x1234, lo=0x5678 -> IDLE next cycle, hi/lo unchanged. flush concurrent with MTLO -> lo unchanged.
- MTHI a=0xDEAD_BEEF in IDLE -> hi=0xDEAD_BEEF next cycle, busy stays 0. DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
